// File: rtl/contadores_param_pkg.sv
// Shared definitions for the parametrised pop-counter bank: FSM encoding,
// counter full-scale constant and the channel-index width check.
package contadores_param_pkg;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        READ  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    function automatic bit idx_fits(input int num_ch, input int idx_w);
        return (1 << idx_w) >= num_ch;
    endfunction

endpackage

// File: rtl/contadores_param_pop_counter.sv
// Single-channel pop counter with saturate or wrap at full scale, a sticky
// overflow flag and a synchronous clear that still honours a coincident pop.
module pop_counter
    import contadores_param_pkg::*;
#(
    parameter int CNT_W    = 5,
    parameter int SAT_MODE = 1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             pop,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    // A clear reloads with the pop of the same edge so no strobe is lost.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= CNT_W'(pop);
            ovf   <= 1'b0;
        end else if (pop) begin
            if (count == CNT_MAX) begin
                ovf   <= 1'b1;
                count <= (SAT_MODE != 0) ? CNT_MAX : '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/contadores_param.sv
// Pop-counter bank: one counter per FIFO channel, single-channel reads and
// full back-to-back sweeps, all outputs registered.
module contadores_param
    import contadores_param_pkg::*;
#(
    parameter int NUM_CH      = 5,
    parameter int CNT_W       = 5,
    parameter int IDX_W       = 3,
    parameter int SAT_MODE    = 1,
    parameter int CLR_ON_READ = 0
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [NUM_CH-1:0] pop,
    input  logic              idle,
    input  logic              req,
    input  logic [IDX_W-1:0]  idx,
    input  logic              req_all,
    output logic              valid,
    output logic [CNT_W-1:0]  data_out,
    output logic [NUM_CH-1:0] ovf,
    output logic              busy
);

    if (!idx_fits(NUM_CH, IDX_W)) begin : g_bad_idx_w
        $error("contadores_param: IDX_W too narrow for NUM_CH");
    end

    state_t             state, next_state;
    logic [IDX_W-1:0]   rd_idx, rd_idx_nxt;
    logic [IDX_W-1:0]   beat, beat_nxt;
    logic [IDX_W-1:0]   sel;
    logic               read_fire;
    logic               valid_nxt, busy_nxt;
    logic [CNT_W-1:0]   rd_data;
    logic [CNT_W-1:0]   counts [NUM_CH];
    logic [NUM_CH-1:0]  clr_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pop_counter #(
            .CNT_W    (CNT_W),
            .SAT_MODE (SAT_MODE)
        ) u_cnt (
            .clk     (clk),
            .reset_L (reset_L),
            .pop     (pop[i]),
            .clr     (clr_vec[i]),
            .count   (counts[i]),
            .ovf     (ovf[i])
        );
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= COUNT;
        end else begin
            state <= next_state;
        end
    end

    // Requests are only taken in COUNT, so anything arriving mid-read or
    // mid-sweep is dropped rather than queued.
    always_comb begin
        next_state = state;
        rd_idx_nxt = rd_idx;
        beat_nxt   = beat;
        sel        = rd_idx;
        read_fire  = 1'b0;
        valid_nxt  = 1'b0;
        busy_nxt   = 1'b0;
        case (state)
            COUNT: begin
                if (idle && req_all) begin
                    next_state = SWEEP;
                    beat_nxt   = '0;
                end else if (idle && req) begin
                    next_state = READ;
                    rd_idx_nxt = idx;
                end
            end
            READ: begin
                sel        = rd_idx;
                read_fire  = 1'b1;
                valid_nxt  = 1'b1;
                next_state = COUNT;
            end
            SWEEP: begin
                sel       = beat;
                read_fire = 1'b1;
                valid_nxt = 1'b1;
                busy_nxt  = 1'b1;
                beat_nxt  = beat + 1'b1;
                if (beat == IDX_W'(NUM_CH - 1)) begin
                    next_state = COUNT;
                end
            end
            default: next_state = COUNT;
        endcase
    end

    // Out-of-range selections fall through to zero and clear nothing.
    always_comb begin
        rd_data = '0;
        clr_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == IDX_W'(i)) begin
                rd_data    = counts[i];
                clr_vec[i] = read_fire && (CLR_ON_READ != 0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd_idx   <= '0;
            beat     <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            data_out <= '0;
        end else begin
            rd_idx <= rd_idx_nxt;
            beat   <= beat_nxt;
            valid  <= valid_nxt;
            busy   <= busy_nxt;
            if (read_fire) begin
                data_out <= rd_data;
            end
        end
    end

endmodule
